// File: rtl/grid_state_engine.sv
`default_nettype none
// ============================================================================
// Module   : grid_state_engine
// Purpose  : Gravity-drop connect-N board engine. Holds a ROWS x COLS board,
//            a one-hot column cursor and the player to move, drops pieces into
//            the lowest free row and detects WIN_LEN-in-line wins
//            (horizontal, vertical, both diagonals) or a full-board draw.
// Ports    : clk, rst (async, active low)
//            put / right / left / new_game : single-cycle command pulses
//            panel[r][c]  : 00 empty, 01 A, 10 B, 11 winning cell
//            play         : one-hot cursor column
//            turn         : 0 = A to move, 1 = B to move
//            invalid_move : one-cycle pulse on put into a full column
//            win_a/win_b/draw : sticky result flags
//            busy         : high while a drop is being placed or checked
// Revision : 1.0 - initial release
// ============================================================================
module grid_state_engine #(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int WIN_LEN = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            put,
    input  logic            right,
    input  logic            left,
    input  logic            new_game,
    output logic [1:0]      panel [0:ROWS-1][0:COLS-1],
    output logic [COLS-1:0] play,
    output logic            turn,
    output logic            invalid_move,
    output logic            win_a,
    output logic            win_b,
    output logic            draw,
    output logic            busy
);
    localparam int CW = $clog2(COLS);

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_DROP  = 2'd1,
        ST_CHECK = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      board_q [0:ROWS-1][0:COLS-1];
    logic [1:0]      board_d [0:ROWS-1][0:COLS-1];
    logic [COLS-1:0] play_q, play_d;
    logic [CW-1:0]   col_q, col_d;
    logic            player_q, player_d;
    logic            turn_q, turn_d;
    logic            invalid_q, invalid_d;
    logic            win_a_q, win_a_d;
    logic            win_b_q, win_b_d;
    logic            draw_q, draw_d;
    logic            busy_q, busy_d;

    logic [CW-1:0]   cur_col;
    logic [1:0]      player_code;
    logic            top_full;
    logic            win_any;
    logic            hit;
    logic            placed;
    logic            win_mask [0:ROWS-1][0:COLS-1];

    assign player_code = player_q ? 2'b10 : 2'b01;

    // Binary index of the one-hot cursor.
    always_comb begin
        cur_col = '0;
        for (int c = 0; c < COLS; c++) begin
            if (play_q[c]) cur_col = CW'(c);
        end
    end

    // With gravity, a full top row means a full board.
    always_comb begin
        top_full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (board_q[0][c] == 2'b00) top_full = 1'b0;
        end
    end

    // Window scan for the latched player. Origins are bounded so that every
    // window lies fully on the board; nothing wraps across an edge.
    always_comb begin
        win_any  = 1'b0;
        hit      = 1'b0;
        win_mask = '{default: 1'b0};
        // horizontal
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c <= COLS - WIN_LEN; c++) begin
                hit = 1'b1;
                for (int k = 0; k < WIN_LEN; k++)
                    if (board_q[r][c+k] != player_code) hit = 1'b0;
                if (hit) begin
                    win_any = 1'b1;
                    for (int k = 0; k < WIN_LEN; k++) win_mask[r][c+k] = 1'b1;
                end
            end
        end
        // vertical
        for (int r = 0; r <= ROWS - WIN_LEN; r++) begin
            for (int c = 0; c < COLS; c++) begin
                hit = 1'b1;
                for (int k = 0; k < WIN_LEN; k++)
                    if (board_q[r+k][c] != player_code) hit = 1'b0;
                if (hit) begin
                    win_any = 1'b1;
                    for (int k = 0; k < WIN_LEN; k++) win_mask[r+k][c] = 1'b1;
                end
            end
        end
        // down-right
        for (int r = 0; r <= ROWS - WIN_LEN; r++) begin
            for (int c = 0; c <= COLS - WIN_LEN; c++) begin
                hit = 1'b1;
                for (int k = 0; k < WIN_LEN; k++)
                    if (board_q[r+k][c+k] != player_code) hit = 1'b0;
                if (hit) begin
                    win_any = 1'b1;
                    for (int k = 0; k < WIN_LEN; k++) win_mask[r+k][c+k] = 1'b1;
                end
            end
        end
        // up-right
        for (int r = WIN_LEN - 1; r < ROWS; r++) begin
            for (int c = 0; c <= COLS - WIN_LEN; c++) begin
                hit = 1'b1;
                for (int k = 0; k < WIN_LEN; k++)
                    if (board_q[r-k][c+k] != player_code) hit = 1'b0;
                if (hit) begin
                    win_any = 1'b1;
                    for (int k = 0; k < WIN_LEN; k++) win_mask[r-k][c+k] = 1'b1;
                end
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        play_d    = play_q;
        col_d     = col_q;
        player_d  = player_q;
        turn_d    = turn_q;
        invalid_d = 1'b0;
        win_a_d   = win_a_q;
        win_b_d   = win_b_q;
        draw_d    = draw_q;
        placed    = 1'b0;

        if (new_game) begin
            // Overrides everything, including a drop in flight.
            state_d = ST_PLAY;
            board_d = '{default: 2'b00};
            play_d  = COLS'(1);
            turn_d  = 1'b0;
            win_a_d = 1'b0;
            win_b_d = 1'b0;
            draw_d  = 1'b0;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (put) begin
                        if (board_q[0][cur_col] != 2'b00) begin
                            invalid_d = 1'b1;
                        end else begin
                            col_d    = cur_col;
                            player_d = turn_q;
                            state_d  = ST_DROP;
                        end
                    end else if (right) begin
                        play_d = {play_q[COLS-2:0], play_q[COLS-1]};
                    end else if (left) begin
                        play_d = {play_q[0], play_q[COLS-1:1]};
                    end
                end
                ST_DROP: begin
                    // Scan upward from the bottom; the first empty cell is the landing spot.
                    for (int r = ROWS - 1; r >= 0; r--) begin
                        if (!placed && board_q[r][col_q] == 2'b00) begin
                            board_d[r][col_q] = player_code;
                            placed            = 1'b1;
                        end
                    end
                    state_d = ST_CHECK;
                end
                ST_CHECK: begin
                    if (win_any) begin
                        if (player_q) win_b_d = 1'b1;
                        else          win_a_d = 1'b1;
                        for (int r = 0; r < ROWS; r++)
                            for (int c = 0; c < COLS; c++)
                                if (win_mask[r][c]) board_d[r][c] = 2'b11;
                        state_d = ST_OVER;
                    end else if (top_full) begin
                        draw_d  = 1'b1;
                        state_d = ST_OVER;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = ST_PLAY;
                    end
                end
                ST_OVER: begin
                end
                default: state_d = ST_PLAY;
            endcase
        end

        busy_d = (state_d == ST_DROP) || (state_d == ST_CHECK);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_PLAY;
            board_q   <= '{default: 2'b00};
            play_q    <= COLS'(1);
            col_q     <= '0;
            player_q  <= 1'b0;
            turn_q    <= 1'b0;
            invalid_q <= 1'b0;
            win_a_q   <= 1'b0;
            win_b_q   <= 1'b0;
            draw_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            board_q   <= board_d;
            play_q    <= play_d;
            col_q     <= col_d;
            player_q  <= player_d;
            turn_q    <= turn_d;
            invalid_q <= invalid_d;
            win_a_q   <= win_a_d;
            win_b_q   <= win_b_d;
            draw_q    <= draw_d;
            busy_q    <= busy_d;
        end
    end

    assign panel        = board_q;
    assign play         = play_q;
    assign turn         = turn_q;
    assign invalid_move = invalid_q;
    assign win_a        = win_a_q;
    assign win_b        = win_b_q;
    assign draw         = draw_q;
    assign busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_grid_state_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_grid_state_engine
// Purpose  : Self-checking bench for grid_state_engine. A board-level model
//            (piece stacks, line search from every cell in four directions)
//            is compared with the default-size DUT every cycle, and literal
//            expectations pin key positions. A second 5x5 / WIN_LEN=3 DUT
//            covers a vertical win with literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_grid_state_engine;
    localparam int MR = 6;
    localparam int MC = 7;
    localparam int ML = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic put, right, left, new_game;
    logic [1:0]    panel [0:MR-1][0:MC-1];
    logic [MC-1:0] play;
    logic turn, invalid_move, win_a, win_b, draw, busy;

    logic put2, right2, left2, new_game2;
    logic [1:0] panel2 [0:4][0:4];
    logic [4:0] play2;
    logic turn2, invalid2, win_a2, win_b2, draw2, busy2;

    grid_state_engine dut (
        .clk(clk), .rst(rst_n), .put(put), .right(right), .left(left),
        .new_game(new_game), .panel(panel), .play(play), .turn(turn),
        .invalid_move(invalid_move), .win_a(win_a), .win_b(win_b),
        .draw(draw), .busy(busy)
    );

    grid_state_engine #(.ROWS(5), .COLS(5), .WIN_LEN(3)) dut2 (
        .clk(clk), .rst(rst_n), .put(put2), .right(right2), .left(left2),
        .new_game(new_game2), .panel(panel2), .play(play2), .turn(turn2),
        .invalid_move(invalid2), .win_a(win_a2), .win_b(win_b2),
        .draw(draw2), .busy(busy2)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [1:0] m_board [0:MR-1][0:MC-1];
    int   m_cur, m_pend, m_col;
    logic m_turn, m_pl, m_inv, m_wa, m_wb, m_draw;
    int   dr [4] = '{0, 1, 1, -1};
    int   dc [4] = '{1, 0, 1,  1};

    task automatic m_reset();
        for (int r = 0; r < MR; r++)
            for (int c = 0; c < MC; c++) m_board[r][c] = 2'b00;
        m_cur = 0; m_pend = 0; m_col = 0;
        m_turn = 0; m_pl = 0; m_inv = 0; m_wa = 0; m_wb = 0; m_draw = 0;
    endtask

    // Piece lands on top of the stack already in the column.
    task automatic m_drop();
        int h;
        h = 0;
        for (int r = 0; r < MR; r++) if (m_board[r][m_col] != 2'b00) h++;
        m_board[MR-1-h][m_col] = m_pl ? 2'b10 : 2'b01;
    endtask

    task automatic m_evaluate();
        logic [1:0] code;
        bit mark [0:MR-1][0:MC-1];
        bit found, full, ok;
        int rr, cc;
        code  = m_pl ? 2'b10 : 2'b01;
        found = 0;
        for (int r = 0; r < MR; r++)
            for (int c = 0; c < MC; c++) mark[r][c] = 0;
        for (int r = 0; r < MR; r++)
            for (int c = 0; c < MC; c++)
                for (int d = 0; d < 4; d++) begin
                    ok = 1;
                    for (int k = 0; k < ML; k++) begin
                        rr = r + dr[d] * k;
                        cc = c + dc[d] * k;
                        if (rr < 0 || rr >= MR || cc < 0 || cc >= MC) ok = 0;
                        else if (m_board[rr][cc] != code) ok = 0;
                    end
                    if (ok) begin
                        found = 1;
                        for (int k = 0; k < ML; k++) mark[r + dr[d]*k][c + dc[d]*k] = 1;
                    end
                end
        if (found) begin
            if (m_pl) m_wb = 1; else m_wa = 1;
            for (int r = 0; r < MR; r++)
                for (int c = 0; c < MC; c++) if (mark[r][c]) m_board[r][c] = 2'b11;
        end else begin
            full = 1;
            for (int r = 0; r < MR; r++)
                for (int c = 0; c < MC; c++) if (m_board[r][c] == 2'b00) full = 0;
            if (full) m_draw = 1;
            else      m_turn = ~m_turn;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reset();
        end else begin
            m_inv = 1'b0;
            if (new_game) begin
                m_reset();
            end else if (m_pend == 1) begin
                m_drop();
                m_pend = 2;
            end else if (m_pend == 2) begin
                m_evaluate();
                m_pend = 0;
            end else if (!(m_wa || m_wb || m_draw)) begin
                if (put) begin
                    if (m_board[0][m_cur] != 2'b00) m_inv = 1'b1;
                    else begin
                        m_col  = m_cur;
                        m_pl   = m_turn;
                        m_pend = 1;
                    end
                end else if (right) m_cur = (m_cur + 1) % MC;
                else if (left)      m_cur = (m_cur + MC - 1) % MC;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit chk_on = 0;
    always @(negedge clk) begin : cmp_blk
        int bad;
        if (chk_on) begin
            bad = 0;
            for (int r = 0; r < MR; r++)
                for (int c = 0; c < MC; c++)
                    if (panel[r][c] !== m_board[r][c]) bad++;
            chk("panel_bad_cells", bad, 0);
            chk("play", play, 32'd1 << m_cur);
            chk("turn", turn, m_turn);
            chk("invalid_move", invalid_move, m_inv);
            chk("win_a", win_a, m_wa);
            chk("win_b", win_b, m_wb);
            chk("draw", draw, m_draw);
            chk("busy", busy, m_pend != 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit p, input bit r, input bit l, input bit n);
        put = p; right = r; left = l; new_game = n;
        @(posedge clk); #2;
        put = 0; right = 0; left = 0; new_game = 0;
    endtask

    task automatic step2(input bit p, input bit r, input bit l, input bit n);
        put2 = p; right2 = r; left2 = l; new_game2 = n;
        @(posedge clk); #2;
        put2 = 0; right2 = 0; left2 = 0; new_game2 = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic goto_col(input int col);
        while (m_cur != col) begin
            if (((col - m_cur + MC) % MC) <= MC / 2) step(0, 1, 0, 0);
            else                                     step(0, 0, 1, 0);
        end
    endtask

    task automatic do_put(input int col);
        goto_col(col);
        step(1, 0, 0, 0);
        idle(2);
    endtask

    int diag_seq [11] = '{0, 1, 1, 2, 3, 2, 2, 3, 6, 3, 3};
    int row_seq  [6]  = '{0, 0, 1, 1, 2, 2};
    int draw_seq [42] = '{0, 2, 2, 0, 0, 2, 2, 0, 0, 2, 2, 0,
                          1, 3, 3, 1, 1, 3, 3, 1, 1, 3, 3, 1,
                          4, 6, 6, 4, 4, 6, 6, 4, 4, 6, 6, 4,
                          5, 5, 5, 5, 5, 5};

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1; put = 0; right = 0; left = 0; new_game = 0;
        put2 = 0; right2 = 0; left2 = 0; new_game2 = 0;
        #3 rst_n = 0;
        @(posedge clk); @(posedge clk); #2;
        rst_n  = 1;
        chk_on = 1;

        // reset state
        chk("reset_play", play, 32'h01);
        chk("reset_turn", turn, 0);
        chk("reset_busy", busy, 0);
        chk("reset_cell53", panel[5][3], 0);
        chk("reset_play2", play2, 32'h01);

        // cursor wrap, put beats right
        step(0, 0, 1, 0);
        chk("left_wrap", play, 32'h40);
        step(0, 1, 0, 0);
        chk("right_wrap", play, 32'h01);
        step(1, 1, 0, 0);
        chk("put_right_cursor", play, 32'h01);
        chk("busy_cycle1", busy, 1);
        idle(1);
        chk("drop_cell50", panel[5][0], 2'b01);
        chk("busy_cycle2", busy, 1);
        idle(1);
        chk("busy_done", busy, 0);
        chk("turn_after_first", turn, 1);

        // second put with commands during busy ignored
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        chk("cell40_B", panel[4][0], 2'b10);
        chk("busy_ignored_play", play, 32'h01);
        do_put(0);
        chk("cell30_A", panel[3][0], 2'b01);
        chk("turn_after_three", turn, 1);

        // full column
        step(0, 0, 0, 1);
        chk("ng_cell30", panel[3][0], 0);
        chk("ng_turn", turn, 0);
        for (int i = 0; i < 6; i++) do_put(3);
        chk("col3_top", panel[0][3], 2'b10);
        step(1, 0, 0, 0);
        chk("invalid_pulse", invalid_move, 1);
        chk("invalid_turn", turn, 0);
        chk("invalid_busy", busy, 0);
        idle(1);
        chk("invalid_clear", invalid_move, 0);

        // new_game during DROP discards the drop
        step(0, 0, 0, 1);
        goto_col(2);
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("ng_drop_cell52", panel[5][2], 0);
        chk("ng_drop_busy", busy, 0);
        chk("ng_drop_play", play, 32'h01);
        idle(2);

        // horizontal win for A on the bottom row
        foreach (row_seq[i]) do_put(row_seq[i]);
        goto_col(3);
        step(1, 0, 0, 0);
        idle(1);
        chk("win_not_yet", win_a, 0);
        idle(1);
        chk("row_win_a", win_a, 1);
        for (int c = 0; c < 4; c++) chk("row_win_cell", panel[5][c], 2'b11);
        chk("row_cell40", panel[4][0], 2'b10);
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        idle(2);
        chk("over_play_hold", play, 32'h08);
        chk("over_cell43", panel[4][3], 0);

        // diagonal win
        step(0, 0, 0, 1);
        foreach (diag_seq[i]) do_put(diag_seq[i]);
        chk("diag_win_a", win_a, 1);
        chk("diag_win_b", win_b, 0);
        chk("diag_50", panel[5][0], 2'b11);
        chk("diag_41", panel[4][1], 2'b11);
        chk("diag_32", panel[3][2], 2'b11);
        chk("diag_23", panel[2][3], 2'b11);
        chk("diag_53", panel[5][3], 2'b01);
        chk("diag_turn", turn, 0);

        // draw
        step(0, 0, 0, 1);
        foreach (draw_seq[i]) do_put(draw_seq[i]);
        chk("draw_flag", draw, 1);
        chk("draw_no_win", win_a, 0);
        chk("draw_cell05", panel[0][5], 2'b10);
        step(0, 0, 0, 1);
        chk("ng_after_draw_cell", panel[5][0], 0);
        chk("ng_after_draw_flag", draw, 0);
        chk("ng_after_draw_turn", turn, 0);

        // reset pulse in the middle of a drop
        goto_col(4);
        step(1, 0, 0, 0);
        #1 rst_n = 0;
        #1 chk("rst_busy", busy, 0);
        @(posedge clk); #2;
        rst_n = 1;
        chk("rst_cell54", panel[5][4], 0);
        chk("rst_play", play, 32'h01);
        step(0, 1, 0, 0);
        chk("first_cmd_after_rst", play, 32'h02);

        // small board, vertical win of three
        step2(1, 0, 0, 0); idle(2);
        step2(0, 1, 0, 0);
        step2(1, 0, 0, 0); idle(2);
        step2(0, 0, 1, 0);
        step2(1, 0, 0, 0); idle(2);
        step2(0, 1, 0, 0);
        step2(1, 0, 0, 0); idle(2);
        step2(0, 0, 1, 0);
        chk("s_no_win_yet", win_a2, 0);
        step2(1, 0, 0, 0); idle(2);
        chk("s_win_a", win_a2, 1);
        chk("s_win_b", win_b2, 0);
        chk("s_cell40", panel2[4][0], 2'b11);
        chk("s_cell30", panel2[3][0], 2'b11);
        chk("s_cell20", panel2[2][0], 2'b11);
        chk("s_cell10", panel2[1][0], 2'b00);
        chk("s_cell41", panel2[4][1], 2'b10);
        chk("s_play", play2, 32'h01);
        chk("s_turn", turn2, 0);
        chk("s_busy", busy2, 0);
        chk("s_draw", draw2, 0);
        chk("s_invalid", invalid2, 0);

        chk_on = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/grid_state_engine.md
GRID_STATE_ENGINE -- requirements
Module: grid_state_engine

Interface
REQ-001 Parameter ROWS, default 6, board height (rows 0 = top .. ROWS-1 = bottom), legal 4..16.
REQ-002 Parameter COLS, default 7, board width (cols 0 = left .. COLS-1 = right), legal 4..16.
REQ-003 Parameter WIN_LEN, default 4, pieces in line needed to win, legal 3..min(ROWS,COLS).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 put  input  1  drop request for current turn in cursor column; single-cycle pulse.
REQ-007 right  input  1  move cursor one column right; single-cycle pulse.
REQ-008 left  input  1  move cursor one column left; single-cycle pulse.
REQ-009 new_game  input  1  clear board and restart; single-cycle pulse.
REQ-010 panel  output  2 per cell, [0:ROWS-1][0:COLS-1]  cell code: 00 empty, 01 player A, 10 player B, 11 winning cell.
REQ-011 play  output  COLS  one-hot cursor column.
REQ-012 turn  output  1  player to move: 0 = A, 1 = B.
REQ-013 invalid_move  output  1  one-cycle pulse on put into a full column.
REQ-014 win_a / win_b  output  1 each  sticky winner flags.
REQ-015 draw  output  1  sticky; board full with no winner.
REQ-016 busy  output  1  high while in DROP or CHECK.

Function
REQ-017 FSM states: PLAY, DROP, CHECK, OVER.
REQ-018 PLAY: command priority new_game > put > right > left; only one command is acted on per cycle.
REQ-019 put in PLAY, column has an empty cell: -> DROP; latch cursor column and turn.
REQ-020 put in PLAY, column full (row 0 occupied): invalid_move = 1 for exactly one cycle; board, turn and state unchanged.
REQ-021 DROP: write the latched player code into the lowest empty row of the latched column (gravity); -> CHECK next cycle; exactly one cell is written.
REQ-022 CHECK: in one cycle, evaluate all horizontal, vertical, down-right and up-right windows of WIN_LEN cells for the latched player.
REQ-023 CHECK, win found: set win_a or win_b per latched player; recode every cell of every winning window to 11 on the same edge; -> OVER.
REQ-024 CHECK, no win, all top-row cells occupied: draw = 1; -> OVER.
REQ-025 CHECK, otherwise: toggle turn; -> PLAY.
REQ-026 Cursor moves in PLAY only: right from COLS-1 wraps to 0; left from 0 wraps to COLS-1; play stays one-hot at all times.
REQ-027 Latency: put to panel update = 1 edge; put to win flag/turn toggle = 2 edges; next put is accepted in the cycle after return to PLAY.
REQ-028 While busy: put, right and left are ignored (not queued); new_game is still honoured.
REQ-029 OVER: put, right and left are ignored; panel, flags and turn hold.
REQ-030 new_game in any state: on the next edge, all cells = 00, play = one-hot col 0, turn = 0, all flags = 0, state = PLAY; any in-flight drop is discarded.
REQ-031 Window checks only include in-bounds cells; no index wraps across board edges.
REQ-032 Simultaneous wins (several windows, including overlapping ones) highlight all winning cells; the flag is set once.

Reset
REQ-033 rst low asynchronously forces: all panel cells 00, play = one-hot col 0, turn 0, invalid_move 0, win_a 0, win_b 0, draw 0, busy 0, state PLAY.
REQ-034 Reset asserted during DROP or CHECK aborts the drop; no partial cell write remains after reset.
REQ-035 First command is accepted on the first rising edge after rst deasserts.

Verification
REQ-036 Default params; put ×3 in col 0 (alternating turns) -> panel[5][0] = 01, [4][0] = 10, [3][0] = 01; turn = 1; busy high for 2 cycles after each put.
REQ-037 Fill col 3 with 6 pieces, then put -> invalid_move high 1 cycle, panel and turn unchanged, state PLAY.
REQ-038 From reset, left ×1 -> play[6] = 1; right ×1 -> play[0] = 1; put and right in the same cycle -> only the drop occurs, cursor unchanged.
REQ-039 A plays cols 0-3 on row 5 (B plays on row 4) -> after the 7th put and 2 edges, win_a = 1, panel[5][0..3] = 11, further put/left/right are ignored.
REQ-040 A completes diagonal [5][0],[4][1],[3][2],[2][3] -> those four cells = 11, win_a = 1; ROWS = 5, COLS = 5, WIN_LEN = 3 vertical win also detected.
REQ-041 Fill the board with no line, board full -> draw = 1; new_game -> all cells 00, turn 0, flags 0; rst pulse mid-DROP -> empty board, no cell written.
